// File: rtl/ham_7_4_pkg.sv
// Shared constants and FSM encoding for the two-requester serial Hamming(7,4)
// decoder scheduler.
package ham_7_4_pkg;

  localparam int CW_W      = 7;
  localparam int DATA_W    = 4;
  localparam int BIT_CNT_W = 3;
  localparam int TO_CNT_W  = 8;
  localparam int GAP_CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RECV,
    S_RESP,
    S_GAP
  } state_t;

endpackage

// File: rtl/ham_7_4_dec_sched_if.sv
// Requester handshakes, response strobe and serial decoder pins of the scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface ham_7_4_dec_sched_if;
  import ham_7_4_pkg::*;

  logic              req0_valid;
  logic [CW_W-1:0]   req0_word;
  logic              req0_ready;
  logic              req1_valid;
  logic [CW_W-1:0]   req1_word;
  logic              req1_ready;
  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_nibble;
  logic              rsp_err;
  logic              dec_datain;
  logic              dec_dvin;
  logic              dec_code;
  logic              dec_dvout;
  logic              busy;

  modport slave (
    input  req0_valid, req0_word, req1_valid, req1_word, dec_code, dec_dvout,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_nibble, rsp_err,
           dec_datain, dec_dvin, busy
  );

  modport master (
    output req0_valid, req0_word, req1_valid, req1_word, dec_code, dec_dvout,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_nibble, rsp_err,
           dec_datain, dec_dvin, busy
  );

endinterface

// File: rtl/ham_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, and on a tie the
// port that did not win last time is chosen.
module ham_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/ham_7_4_dec_sched.sv
// Scheduler sharing one serial Hamming(7,4) decoder between two requesters:
// round-robin grant, bit-serial send, serial nibble collect, tagged response.
module ham_7_4_dec_sched
  import ham_7_4_pkg::*;
#(
  parameter int TIMEOUT = 32,
  parameter int GAP     = 1
) (
  input logic                clk,
  input logic                reset,
  ham_7_4_dec_sched_if.slave bus
);

  localparam logic [TO_CNT_W-1:0]  TO_LAST   = TO_CNT_W'(TIMEOUT - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST  = GAP_CNT_W'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [BIT_CNT_W-1:0] SEND_LAST = BIT_CNT_W'(CW_W - 1);
  localparam logic [BIT_CNT_W-1:0] RECV_LAST = BIT_CNT_W'(DATA_W - 1);

  state_t                state;
  state_t                state_nx;
  logic [1:0]            grant;
  logic [CW_W-1:0]       sel_word;
  logic                  last_q;
  logic                  id_q;
  logic [CW_W-2:0]       word_q;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [TO_CNT_W-1:0]   to_cnt;
  logic [GAP_CNT_W-1:0]  gap_cnt;
  logic [DATA_W-1:0]     nib_q;
  logic                  err_q;
  logic                  dvin_q;
  logic                  datain_q;

  logic                  idle;
  logic                  resp;
  logic                  ready0;
  logic                  ready1;
  logic                  rsp_id;
  logic                  rsp_err;
  logic [DATA_W-1:0]     rsp_nibble;

  ham_rr_arb2 u_arb (
    .valid ({bus.req1_valid, bus.req0_valid}),
    .last  (last_q),
    .grant (grant)
  );

  assign sel_word = grant[1] ? bus.req1_word : bus.req0_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A low dvout in the last WAIT cycle still counts as a reply, not a timeout.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (grant != 2'b00) state_nx = S_SEND;
      S_SEND: if (bit_cnt == SEND_LAST) state_nx = S_WAIT;
      S_WAIT: begin
        if (!bus.dec_dvout) begin
          state_nx = S_RECV;
        end else if (to_cnt == TO_LAST) begin
          state_nx = S_RESP;
        end
      end
      S_RECV: if (bus.dec_dvout || (bit_cnt == RECV_LAST)) state_nx = S_RESP;
      S_RESP: state_nx = (GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:  if (gap_cnt == GAP_LAST) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Bit 0 goes out straight from the grant, so only the upper six bits are held
  // and shifted down while the frame is on the wire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      word_q   <= '0;
      bit_cnt  <= '0;
      to_cnt   <= '0;
      gap_cnt  <= '0;
      nib_q    <= '0;
      err_q    <= 1'b0;
      dvin_q   <= 1'b1;
      datain_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant != 2'b00) begin
            id_q     <= grant[1];
            last_q   <= grant[1];
            word_q   <= sel_word[CW_W-1:1];
            datain_q <= sel_word[0];
            dvin_q   <= 1'b0;
            bit_cnt  <= '0;
            nib_q    <= '0;
            err_q    <= 1'b0;
          end
        end
        S_SEND: begin
          if (bit_cnt == SEND_LAST) begin
            dvin_q   <= 1'b1;
            datain_q <= 1'b0;
            to_cnt   <= '0;
          end else begin
            bit_cnt  <= bit_cnt + 1'b1;
            datain_q <= word_q[0];
            word_q   <= word_q >> 1;
          end
        end
        S_WAIT: begin
          if (!bus.dec_dvout) begin
            nib_q[0] <= bus.dec_code;
            bit_cnt  <= BIT_CNT_W'(1);
          end else if (to_cnt == TO_LAST) begin
            err_q    <= 1'b1;
          end else begin
            to_cnt   <= to_cnt + 1'b1;
          end
        end
        S_RECV: begin
          if (!bus.dec_dvout) begin
            nib_q[bit_cnt[1:0]] <= bus.dec_code;
            bit_cnt             <= bit_cnt + 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
        S_RESP: gap_cnt <= '0;
        S_GAP:  gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Readies are held low during reset even though the state already reads IDLE.
  always_comb begin
    idle       = (state == S_IDLE);
    resp       = (state == S_RESP);
    ready0     = idle && !reset && grant[0];
    ready1     = idle && !reset && grant[1];
    rsp_id     = resp && id_q;
    rsp_err    = resp && err_q;
    rsp_nibble = (resp && !err_q) ? nib_q : '0;
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = resp;
  assign bus.rsp_id     = rsp_id;
  assign bus.rsp_nibble = rsp_nibble;
  assign bus.rsp_err    = rsp_err;
  assign bus.dec_datain = datain_q;
  assign bus.dec_dvin   = dvin_q;
  assign bus.busy       = !idle;

endmodule

// File: tb/tb_ham_7_4_dec_sched.sv
// Bench for ham_7_4_dec_sched: a behavioural serial decoder answers each frame,
// and a scoreboard of expected responses is checked as responses appear.
module tb_ham_7_4_dec_sched;
  import ham_7_4_pkg::*;

  localparam int TIMEOUT = 32;
  localparam int GAP     = 1;

  typedef struct {
    logic       id;
    logic [6:0] word;
    int         dly;
    int         len;
    logic [3:0] bits;
    logic [3:0] nib;
    logic       err;
    int         lat;
  } vec_t;

  typedef struct {
    int         dly;
    int         len;
    logic [3:0] bits;
  } beh_t;

  typedef struct {
    logic       id;
    logic [6:0] word;
    logic [3:0] nib;
    logic       err;
    int         lat;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ham_7_4_dec_sched_if bus ();

  ham_7_4_dec_sched #(
    .TIMEOUT (TIMEOUT),
    .GAP     (GAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] port0_q[$];
  logic [6:0] port1_q[$];
  beh_t       beh_q[$];
  exp_t       exp_q[$];
  logic [6:0] cap_q[$];
  int         wend_q[$];

  int errors = 0;
  int checks = 0;
  bit tight          = 1'b0;
  bit rsp_seen       = 1'b0;
  bit abort_expected = 1'b0;
  int last_rsp_cyc   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    beh_t b;
    exp_t e;
    b.dly  = v.dly;
    b.len  = v.len;
    b.bits = v.bits;
    e.id   = v.id;
    e.word = v.word;
    e.nib  = v.nib;
    e.err  = v.err;
    e.lat  = v.lat;
    beh_q.push_back(b);
    exp_q.push_back(e);
    if (v.id) port1_q.push_back(v.word);
    else      port0_q.push_back(v.word);
  endtask

  task automatic waitAccepted(input int budget);
    int k;
    k = 0;
    while ((port0_q.size() + port1_q.size()) > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("grant_wait", port0_q.size() + port1_q.size(), 0);
  endtask

  task automatic waitDrain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(name, exp_q.size(), 0);
    if (exp_q.size() > 0) begin
      exp_q.delete();
      beh_q.delete();
      cap_q.delete();
      wend_q.delete();
    end
  endtask

  // Requester 0 driver: present the head of its queue, pop on valid & ready.
  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_word  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (port0_q.size() > 0) begin
        bus.req0_valid = 1'b1;
        bus.req0_word  = port0_q[0];
      end else begin
        bus.req0_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.req0_valid && bus.req0_ready) void'(port0_q.pop_front());
    end
  end

  initial begin
    bus.req1_valid = 1'b0;
    bus.req1_word  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (port1_q.size() > 0) begin
        bus.req1_valid = 1'b1;
        bus.req1_word  = port1_q[0];
      end else begin
        bus.req1_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.req1_valid && bus.req1_ready) void'(port1_q.pop_front());
    end
  end

  // Serial decoder model: captures each frame, then replies per the next behaviour.
  initial begin
    bus.dec_dvout = 1'b1;
    bus.dec_code  = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus.dec_dvin && !reset) begin
        int         n;
        logic [6:0] w;
        beh_t       b;
        n = 0;
        w = '0;
        if (tight && rsp_seen) checkOutput("frame_spacing", cyc - last_rsp_cyc, GAP + 2);
        rsp_seen = 1'b0;
        while (!bus.dec_dvin) begin
          if (n < 7) w[n] = bus.dec_datain;
          n++;
          @(negedge clk);
        end
        if (abort_expected) begin
          checkOutput("abort_short_frame", (n < 7), 1);
          abort_expected = 1'b0;
        end else begin
          checkOutput("frame_len", n, 7);
          cap_q.push_back(w);
          wend_q.push_back(cyc);
          checkOutput("beh_available", beh_q.size() > 0, 1);
          if (beh_q.size() > 0) begin
            b = beh_q.pop_front();
            repeat (b.dly) @(negedge clk);
            for (int i = 0; i < b.len; i++) begin
              bus.dec_dvout = 1'b0;
              bus.dec_code  = (i < 4) ? b.bits[2'(i)] : 1'b0;
              @(negedge clk);
            end
            bus.dec_dvout = 1'b1;
            bus.dec_code  = 1'b0;
          end
        end
      end
    end
  end

  // Response monitor: pops the scoreboard and the captured frame for each strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        exp_t       e;
        logic [6:0] w;
        int         wend;
        last_rsp_cyc = cyc;
        rsp_seen     = 1'b1;
        checkOutput("rsp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("rsp_id", bus.rsp_id, e.id);
          checkOutput("rsp_nibble", bus.rsp_nibble, e.nib);
          checkOutput("rsp_err", bus.rsp_err, e.err);
          checkOutput("frame_present", cap_q.size() > 0, 1);
          if (cap_q.size() > 0) begin
            w    = cap_q.pop_front();
            wend = wend_q.pop_front();
            checkOutput("frame_word", w, e.word);
            checkOutput("rsp_latency", cyc - wend, e.lat);
          end
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: run exceeded 20000 cycles, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int   k;
    vec_t v;

    // id, word, delay, dvout-low cycles, code bits, nibble, err, latency from WAIT entry
    tbl[0] = '{1'b0, 7'b0000010,  3, 4, 4'b0000, 4'h0, 1'b0, 7};
    tbl[1] = '{1'b0, 7'b1010101,  0, 4, 4'b1101, 4'hD, 1'b0, 4};
    tbl[2] = '{1'b1, 7'b1100110,  1, 4, 4'b0110, 4'h6, 1'b0, 5};
    tbl[3] = '{1'b0, 7'b0111000,  0, 0, 4'b0000, 4'h0, 1'b1, TIMEOUT};
    tbl[4] = '{1'b1, 7'b1001011,  2, 4, 4'b1010, 4'hA, 1'b0, 6};
    tbl[5] = '{1'b0, 7'b0001111,  0, 2, 4'b0011, 4'h0, 1'b1, 3};
    tbl[6] = '{1'b0, 7'b1111111,  0, 4, 4'b1111, 4'hF, 1'b0, 4};
    tbl[7] = '{1'b1, 7'b0101010,  0, 6, 4'b1001, 4'h9, 1'b0, 4};
    tbl[8] = '{1'b1, 7'b0110011, 31, 4, 4'b0101, 4'h5, 1'b0, 35};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_dvin", bus.dec_dvin, 1'b1);
    checkOutput("reset_datain", bus.dec_datain, 1'b0);
    checkOutput("reset_ready0", bus.req0_ready, 1'b0);
    checkOutput("reset_ready1", bus.req1_ready, 1'b0);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("reset_rsp_id", bus.rsp_id, 1'b0);
    checkOutput("reset_rsp_nibble", bus.rsp_nibble, 4'h0);
    checkOutput("reset_rsp_err", bus.rsp_err, 1'b0);
    checkOutput("reset_busy", bus.busy, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] table-driven transactions");
    tight    = 1'b1;
    rsp_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i]);
      waitAccepted(200);
    end
    waitDrain("table_drain", 400);

    $display("[TB] round-robin with both requesters held valid");
    rsp_seen = 1'b0;
    v = '{1'b0, 7'h11, 0, 4, 4'b0001, 4'h1, 1'b0, 4}; applyStimulus(v);
    v = '{1'b1, 7'h33, 0, 4, 4'b0010, 4'h2, 1'b0, 4}; applyStimulus(v);
    v = '{1'b0, 7'h22, 0, 4, 4'b0100, 4'h4, 1'b0, 4}; applyStimulus(v);
    v = '{1'b1, 7'h44, 0, 4, 4'b1000, 4'h8, 1'b0, 4}; applyStimulus(v);
    waitDrain("rr_drain", 300);

    $display("[TB] requester 1 alone, back-to-back");
    rsp_seen = 1'b0;
    v = '{1'b1, 7'h55, 0, 4, 4'b1100, 4'hC, 1'b0, 4}; applyStimulus(v);
    v = '{1'b1, 7'h66, 1, 4, 4'b0011, 4'h3, 1'b0, 5}; applyStimulus(v);
    waitDrain("solo_drain", 200);

    $display("[TB] reset in the middle of a frame");
    tight          = 1'b0;
    rsp_seen       = 1'b0;
    abort_expected = 1'b1;
    port0_q.push_back(7'b1011010);
    k = 0;
    while (bus.dec_dvin && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("abort_frame_start", bus.dec_dvin, 1'b0);
    @(negedge clk);
    @(negedge clk);
    v = '{1'b0, 7'b0110110, 0, 4, 4'b0111, 4'h7, 1'b0, 4}; applyStimulus(v);
    v = '{1'b1, 7'b1110001, 1, 4, 4'b1000, 4'h8, 1'b0, 5}; applyStimulus(v);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_dvin", bus.dec_dvin, 1'b1);
    checkOutput("async_reset_datain", bus.dec_datain, 1'b0);
    checkOutput("async_reset_ready0", bus.req0_ready, 1'b0);
    checkOutput("async_reset_ready1", bus.req1_ready, 1'b0);
    checkOutput("async_reset_busy", bus.busy, 1'b0);
    checkOutput("async_reset_rsp_valid", bus.rsp_valid, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    waitDrain("post_reset_drain", 300);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ham_7_4_dec_sched.md
Name: ham_7_4_dec_sched

Overview:
Controller that shares one serial ham_7_4_dec instance between two requesters.
- Accepts 7-bit codewords over valid/ready from two ports, arbitrating round-robin.
- Serializes the winner onto the decoder's datain/dvin pins, then collects the serial decoded nibble from code/dvout.
- Returns the 4-bit result tagged with requester id, plus an error flag for timeout or short response.

Parameters:
TIMEOUT, 32, max cycles in WAIT for decoder dvout to go low before error response (range 2..255)
GAP, 1, extra idle cycles (dvin high) after each response before next grant (range 0..15)

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high; clears all state immediately
req0_valid  in  1  requester 0 has codeword
req0_word  in  7  requester 0 codeword, bit 0 transmitted first
req0_ready  out  1  requester 0 accepted this cycle (valid & ready)
req1_valid  in  1  requester 1 has codeword
req1_word  in  7  requester 1 codeword
req1_ready  out  1  requester 1 accepted this cycle
rsp_valid  out  1  one-cycle response strobe, no backpressure
rsp_id  out  1  requester of this response
rsp_nibble  out  4  decoded data, first received bit = bit 0; 0 when rsp_err
rsp_err  out  1  timeout or short decoder frame
dec_datain  out  1  serial codeword bit to decoder
dec_dvin  out  1  active-low frame valid to decoder
dec_code  in  1  serial decoded bit from decoder
dec_dvout  in  1  active-low decoded-bit valid from decoder
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - req*_ready=0, rsp_valid=0, rsp_id=0, rsp_nibble=0, rsp_err=0.
  - dec_datain=0, dec_dvin=1, busy=0.
  - State IDLE, round-robin pointer last=1, so req0 wins first.
- Reset mid-operation aborts the in-flight word with no response. dec_dvin returns high asynchronously.
- States: IDLE, SEND, WAIT, RECV, RESP, GAP.
- IDLE, arbitration:
  - Grant goes to the requester whose valid is high.
  - If both valid, grant goes to the one != last.
  - req*_ready is combinational from the valids, asserted only in IDLE, only for the granted port.
  - On grant (cycle T): latch word and id, update last, go to SEND.
- SEND:
  - Cycles T+1..T+7: dec_dvin=0 and dec_datain=word[i] for i=0..6. Both are registered outputs.
  - After the 7th bit: dec_dvin=1, dec_datain=0, go to WAIT.
- WAIT:
  - Timeout counter starts at 0 on entry.
  - First cycle with dec_dvout=0: sample dec_code into bit 0, go to RECV.
  - If the counter reaches TIMEOUT with no low dvout: go to RESP with err=1.
- RECV:
  - Samples bits 1..3 on consecutive cycles while dec_dvout=0.
  - dec_dvout high before bit 3 is captured: go to RESP with err=1.
  - After bit 3: go to RESP.
  - dec_dvout staying low beyond 4 cycles is ignored.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_id, rsp_nibble and rsp_err.
  - Then go to GAP if GAP>0, else IDLE.
- GAP: GAP cycles with dec_dvin=1, then IDLE.
- Frame spacing: the IDLE grant cycle guarantees at least 1 dvin-high cycle between frames.
- dec_dvout and dec_code are ignored outside WAIT/RECV.
- Requester valid may drop without acceptance: no grant occurs and no state is retained.
- Minimum grant-to-response latency: 7 (SEND) + 1 (WAIT) + 3 (RECV) + 1 = 12 cycles after T, plus decoder delay.

Decomposition:
- Package ham_7_4_pkg:
  - Constants CW_W=7, DATA_W=4.
  - State enum.
  - Bit-counter width (3).
  - Timeout counter width (8).
- One sub-module: ham_rr_arb2, a 2-way round-robin arbiter (valids, last pointer -> grant vector). Used combinationally in IDLE.
- Shift/serialize and collect logic stays in the top module.

Test Plan:
1. req0_word=7'b0000010, decoder model answers 3 cycles after frame with code bits 0,0,0,0 -> dec_dvin low exactly 7 cycles; datain 0,1,0,0,0,0,0; one rsp_valid with id=0, nibble=4'h0, err=0.
2. Decoder model returns code 1,0,1,1 -> rsp_nibble=4'b1101.
3. req0 and req1 held valid continuously for 4 transactions -> grants ordered 0,1,0,1. Only req1 valid -> req1 granted back-to-back, with GAP+1 dvin-high cycles between frames.
4. Decoder never drives dvout low, TIMEOUT=32 -> rsp_valid with err=1, nibble=0, exactly 32 cycles after WAIT entry. Next pending request is then granted normally.
5. dvout low for only 2 cycles -> rsp_err=1, nibble=0. Following transaction decodes correctly.
6. reset pulsed after 3 SEND bits -> dec_dvin=1 and readys 0 without waiting for clk edge; no response emitted. After release, req0 is granted fresh and all 7 bits are sent.
